// File: rtl/line_window_buffer_pkg.sv
// Shared types and helpers for the K-row sliding-window line buffer.
// Parameter legality is checked by LWB_PARAM_CHECK inside the top level.
`define LWB_PARAM_CHECK(cond) \
  always_ff @(posedge clk) assert (cond);

package line_window_buffer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_FILL,
    S_EMIT,
    S_WAIT
  } state_t;

  function automatic int row_bits(input int w, input int p);
    return w * p;
  endfunction

  function automatic int half_k(input int k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/line_window_buffer_line_shift_reg.sv
// K x RB line register: slice 0 is the oldest row, slice K-1 the newest.
// Synchronous clear zeroes every line so top padding falls out naturally.
module line_shift_reg #(
  parameter int K  = 3,
  parameter int RB = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            step,
  input  logic [RB-1:0]   new_row,
  output logic [K*RB-1:0] rows
);

  localparam int KW = K * RB;

  always_ff @(posedge clk) begin
    if (clr) begin
      rows <= '0;
    end else if (step) begin
      rows <= (rows >> RB) | (KW'(new_row) << ((K - 1) * RB));
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// Sliding K-row window over an image fetched row by row from frame memory.
// One row of prefetch is staged so windows stream back-to-back.
module line_window_buffer
  import line_window_buffer_pkg::*;
#(
  parameter int  IMG_W    = 1280,
  parameter int  PIX_W    = 1,
  parameter int  IMG_H    = 720,
  parameter int  K        = 3,
  parameter int  ROW_AW   = 10,
  localparam int ROW_BITS = row_bits(IMG_W, PIX_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  fetch_req,
  output logic [ROW_AW-1:0]     fetch_addr,
  input  logic                  fetch_valid,
  input  logic [ROW_BITS-1:0]   fetch_data,
  output logic [K*ROW_BITS-1:0] win_rows,
  output logic [ROW_AW-1:0]     win_row_idx,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  frame_done
);

  localparam int H = half_k(K);

  `LWB_PARAM_CHECK((K % 2 == 1) && (K >= 1) && (IMG_H >= 1) &&
                   ((64'd1 << ROW_AW) >= 64'(IMG_H)))

  state_t                state, state_n;
  logic [31:0]           ld;
  logic [31:0]           nxt;
  logic [ROW_BITS-1:0]   stage_q;
  logic                  stage_full;
  logic [ROW_BITS-1:0]   new_row;
  logic                  got, hs, last, ld_in;
  logic                  step, start_acc;

  assign got        = fetch_req & fetch_valid;
  assign win_valid  = (state == S_EMIT);
  assign busy       = (state != S_IDLE);
  assign hs         = win_valid & win_ready;
  assign last       = (win_row_idx == ROW_AW'(IMG_H - 1));
  assign frame_done = hs & last;
  assign ld_in      = (ld < 32'(IMG_H));
  assign nxt        = ld + 32'd1;

  // ld always names the row that the next step shifts in (r+H, then r+1+H)
  always_comb begin
    new_row = '0;
    if (ld_in) begin
      new_row = stage_full ? stage_q : fetch_data;
    end
  end

  always_comb begin
    state_n   = state;
    step      = 1'b0;
    start_acc = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_n   = (H > 0) ? S_PRIME : S_FILL;
        end
      end
      S_PRIME: begin
        if (!ld_in || got) begin
          step = 1'b1;
          if (ld == 32'(H - 1)) state_n = S_FILL;
        end
      end
      S_FILL: begin
        if (!ld_in || got) begin
          step    = 1'b1;
          state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        if (hs) begin
          if (last) state_n = S_IDLE;
          else if (stage_full || got || !ld_in) step = 1'b1;
          else state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (got) begin
          step    = 1'b1;
          state_n = S_EMIT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ld          <= '0;
      win_row_idx <= '0;
      stage_q     <= '0;
      stage_full  <= 1'b0;
      fetch_req   <= 1'b0;
      fetch_addr  <= '0;
    end else begin
      state <= state_n;
      if (start_acc) begin
        ld          <= '0;
        win_row_idx <= '0;
        stage_full  <= 1'b0;
        fetch_req   <= 1'b1;
        fetch_addr  <= '0;
      end
      if (step) begin
        ld         <= nxt;
        stage_full <= 1'b0;
        fetch_req  <= (nxt < 32'(IMG_H));
        if (nxt < 32'(IMG_H)) fetch_addr <= ROW_AW'(nxt);
      end else if (got) begin
        // consumer stalled: park the prefetched row
        stage_q    <= fetch_data;
        stage_full <= 1'b1;
        fetch_req  <= 1'b0;
      end
      if (hs && !last) win_row_idx <= win_row_idx + ROW_AW'(1);
    end
  end

  line_shift_reg #(
    .K  (K),
    .RB (ROW_BITS)
  ) u_lines (
    .clk     (clk),
    .clr     (rst | start_acc),
    .step    (step),
    .new_row (new_row),
    .rows    (win_rows)
  );

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: K=3/IMG_H=4 and K=5/IMG_H=2 instances.
// Expected windows come from an index model pushed to scoreboard queues.
module tb_line_window_buffer;

  localparam int RB = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start_a, busy_a, freq_a, fvalid_a, wv_a, wr_a, done_a;
  logic [AW-1:0] faddr_a, idx_a;
  logic [RB-1:0] fdata_a;
  logic [47:0]   win_a;

  logic          start_b, busy_b, freq_b, fvalid_b, wv_b, wr_b, done_b;
  logic [AW-1:0] faddr_b, idx_b;
  logic [RB-1:0] fdata_b;
  logic [79:0]   win_b;

  int   tests = 0;
  int   fails = 0;
  int   lat;
  logic mem_on, man_valid;
  int   wcnt;

  function automatic logic [15:0] rv(input int a);
    logic [7:0] b;
    b = 8'(8'hA0 + a);
    return {b, b};
  endfunction

  function automatic logic [127:0] exp_win(input int k, input int himg, input int r);
    logic [127:0] w;
    int hh;
    w  = '0;
    hh = (k - 1) / 2;
    for (int j = 0; j < k; j++) begin
      int src;
      src = r - hh + j;
      if (src >= 0 && src < himg) w[j*16 +: 16] = rv(src);
    end
    return w;
  endfunction

  assign fdata_a  = rv(int'(faddr_a));
  assign fvalid_a = mem_on ? (freq_a && wcnt >= lat) : man_valid;
  assign fdata_b  = rv(int'(faddr_b));
  assign fvalid_b = freq_b;

  always @(posedge clk) begin
    if (rst || !freq_a || fvalid_a) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  line_window_buffer #(
    .IMG_W(4), .PIX_W(4), .IMG_H(4), .K(3), .ROW_AW(AW)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a),
    .fetch_req(freq_a), .fetch_addr(faddr_a), .fetch_valid(fvalid_a),
    .fetch_data(fdata_a), .win_rows(win_a), .win_row_idx(idx_a),
    .win_valid(wv_a), .win_ready(wr_a), .frame_done(done_a)
  );

  line_window_buffer #(
    .IMG_W(4), .PIX_W(4), .IMG_H(2), .K(5), .ROW_AW(AW)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
    .fetch_req(freq_b), .fetch_addr(faddr_b), .fetch_valid(fvalid_b),
    .fetch_data(fdata_b), .win_rows(win_b), .win_row_idx(idx_b),
    .win_valid(wv_b), .win_ready(wr_b), .frame_done(done_b)
  );

  logic [127:0] qr_a[$];
  int           qi_a[$];
  logic [127:0] qr_b[$];
  int           qi_b[$];
  int           fa[$];
  int           fb[$];
  int           cyc = 0;
  int           first_hs, last_hs, hs_cnt_a;
  logic         done_seen_a, done_seen_b, saw_wait;
  logic         prev_req_a = 1'b0;
  logic         prev_got_a = 1'b0;
  logic [AW-1:0] prev_addr_a = '0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    logic [127:0] er;
    int ei;
    cyc++;
    if (wv_a && wr_a) begin
      if (qr_a.size() == 0) chk("win_a_unexpected", 1, 0);
      else begin
        er = qr_a.pop_front();
        ei = qi_a.pop_front();
        chk("win_a_rows", win_a, er);
        chk("win_a_idx", idx_a, ei);
        chk("done_a", done_a, ei == 3);
        if (ei == 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt_a++;
        if (done_a) done_seen_a = 1'b1;
      end
    end
    if (freq_a && fvalid_a) fa.push_back(int'(faddr_a));
    if (prev_req_a && !prev_got_a) begin
      chk("freq_a_held", freq_a, 1);
      chk("faddr_a_held", faddr_a, prev_addr_a);
    end
    if (busy_a && !wv_a && freq_a && hs_cnt_a > 0) saw_wait = 1'b1;
    prev_req_a  = freq_a && !rst;
    prev_got_a  = freq_a && fvalid_a;
    prev_addr_a = faddr_a;
    if (wv_b && wr_b) begin
      if (qr_b.size() == 0) chk("win_b_unexpected", 1, 0);
      else begin
        er = qr_b.pop_front();
        ei = qi_b.pop_front();
        chk("win_b_rows", win_b, er);
        chk("win_b_idx", idx_b, ei);
        chk("done_b", done_b, ei == 1);
        if (done_b) done_seen_b = 1'b1;
      end
    end
    if (freq_b && fvalid_b) fb.push_back(int'(faddr_b));
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a();
    for (int r = 0; r < 4; r++) begin
      qr_a.push_back(exp_win(3, 4, r));
      qi_a.push_back(r);
    end
  endtask

  task automatic go_a();
    done_seen_a = 1'b0;
    saw_wait    = 1'b0;
    hs_cnt_a    = 0;
    start_a     = 1'b1;
    step();
    start_a     = 1'b0;
  endtask

  task automatic run_a(input int budget);
    int n;
    n = 0;
    while (!done_seen_a && n < budget) begin
      step();
      n++;
    end
    chk("run_a_timeout", done_seen_a, 1);
  endtask

  task automatic chk_fa4(input string tag);
    chk({tag, "_count"}, fa.size(), 4);
    if (fa.size() == 4) begin
      for (int i = 0; i < 4; i++) chk({tag, "_addr"}, fa[i], i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [47:0] hold_w;
    logic [AW-1:0] hold_i;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    wr_a = 1'b1; wr_b = 1'b1;
    mem_on = 1'b1; man_valid = 1'b0; lat = 0;
    done_seen_a = 1'b0; done_seen_b = 1'b0; saw_wait = 1'b0;
    first_hs = 0; last_hs = 0; hs_cnt_a = 0;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_busy", busy_a, 0);
    chk("rst_freq", freq_a, 0);
    chk("rst_faddr", faddr_a, 0);
    chk("rst_win", win_a, 0);
    chk("rst_idx", idx_a, 0);
    chk("rst_valid", wv_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_win_b", win_b, 0);

    // zero-latency memory, ready high
    fa.delete();
    push_a();
    go_a();
    chk("lat_freq", freq_a, 1);
    chk("lat_faddr", faddr_a, 0);
    chk("lat_busy", busy_a, 1);
    chk("lat_valid_c1", wv_a, 0);
    step();
    chk("lat_valid_c2", wv_a, 0);
    step();
    chk("lat_valid_c3", wv_a, 1);
    run_a(20);
    chk("throughput", last_hs - first_hs, 3);
    chk_fa4("zl_fetch");
    chk("zl_queue_empty", qr_a.size(), 0);
    chk("zl_end_busy", busy_a, 0);
    chk("zl_end_valid", wv_a, 0);

    // 5-cycle memory
    lat = 4;
    fa.delete();
    push_a();
    go_a();
    run_a(100);
    chk("slow_wait_seen", saw_wait, 1);
    chk_fa4("slow_fetch");
    lat = 0;

    // consumer stall at r=1
    fa.delete();
    push_a();
    go_a();
    n = 0;
    while (!(wv_a && idx_a == 1) && n < 20) begin
      step();
      n++;
    end
    chk("stall_reach_r1", wv_a && idx_a == 1, 1);
    wr_a   = 1'b0;
    hold_w = win_a;
    hold_i = idx_a;
    repeat (10) begin
      step();
      chk("stall_win", win_a, hold_w);
      chk("stall_idx", idx_a, hold_i);
      chk("stall_valid", wv_a, 1);
    end
    chk("stall_freq_idle", freq_a, 0);
    chk_fa4("stall_fetch");
    wr_a = 1'b1;
    run_a(20);
    chk_fa4("stall_fetch_end");

    // K=5 with a 2-row image
    fb.delete();
    for (int r = 0; r < 2; r++) begin
      qr_b.push_back(exp_win(5, 2, r));
      qi_b.push_back(r);
    end
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    n = 0;
    while (!done_seen_b && n < 20) begin
      step();
      n++;
    end
    chk("k5_done", done_seen_b, 1);
    chk("k5_fetch_count", fb.size(), 2);
    if (fb.size() == 2) begin
      chk("k5_addr0", fb[0], 0);
      chk("k5_addr1", fb[1], 1);
    end
    chk("k5_queue_empty", qr_b.size(), 0);

    // reset while waiting on a slow fetch
    lat = 4;
    push_a();
    go_a();
    n = 0;
    while (!(hs_cnt_a >= 1 && busy_a && !wv_a && freq_a) && n < 50) begin
      step();
      n++;
    end
    chk("abort_in_wait", hs_cnt_a >= 1 && busy_a && !wv_a && freq_a, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    qr_a.delete();
    qi_a.delete();
    chk("abort_busy", busy_a, 0);
    chk("abort_freq", freq_a, 0);
    chk("abort_valid", wv_a, 0);
    chk("abort_win", win_a, 0);
    mem_on = 1'b0;
    man_valid = 1'b1;
    step();
    man_valid = 1'b0;
    mem_on = 1'b1;
    chk("abort_pulse_busy", busy_a, 0);
    chk("abort_pulse_freq", freq_a, 0);
    chk("abort_pulse_faddr", faddr_a, 0);
    chk("abort_pulse_valid", wv_a, 0);
    chk("abort_pulse_win", win_a, 0);
    chk("abort_pulse_idx", idx_a, 0);
    lat = 0;
    fa.delete();
    push_a();
    go_a();
    run_a(20);
    chk_fa4("after_abort_fetch");
    chk("after_abort_queue", qr_a.size(), 0);

    // start pulsed mid-frame is ignored
    push_a();
    go_a();
    n = 0;
    while (!(wv_a && idx_a == 1) && n < 20) begin
      step();
      n++;
    end
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    run_a(20);
    chk("restart_queue", qr_a.size(), 0);
    repeat (3) step();
    chk("restart_busy", busy_a, 0);
    chk("restart_valid", wv_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Parametrised K-row sliding-window line buffer feeding the row-wise convolution datapath.
- Fetches full image rows from frame memory over a req/valid handshake and zero-pads rows outside the image (top and bottom).
- Presents K vertically adjacent rows per output row over a valid/ready stream.
- One staged prefetch sustains one window per cycle when memory and consumer allow.

Parameters:
- IMG_W, 1280, pixels per row
- PIX_W, 1, bits per pixel; ROW_BITS = IMG_W*PIX_W
- IMG_H, 720, rows per frame; must be >= 1
- K, 3, window rows; odd, >= 1; H = (K-1)/2
- ROW_AW, 10, row address width; 2^ROW_AW >= IMG_H

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE, ignored otherwise
- busy  out  1  high from the cycle after start is accepted until frame_done
- fetch_req  out  1  row read request
- fetch_addr  out  ROW_AW  row index requested
- fetch_valid  in  1  fetch_data valid; honoured only while fetch_req=1
- fetch_data  in  ROW_BITS  fetched row
- win_rows  out  K*ROW_BITS  window; slice 0 (LSBs) = top row r-H, slice K-1 = bottom row r+H
- win_row_idx  out  ROW_AW  output row r of current window
- win_valid  out  1  window valid
- win_ready  in  1  consumer accepts
- frame_done  out  1  one-cycle pulse on final handshake (r = IMG_H-1)

Behaviour:
- Reset: all K line registers, stage register, win_row_idx and fetch_addr = 0; busy, fetch_req, win_valid, frame_done = 0; state IDLE; stage empty. Reset mid-frame aborts immediately; a fetch_valid arriving after reset is ignored.
- Step: shift lines up (slice0 <= slice1 ... slice K-2 <= slice K-1); slice K-1 <= new row. New row is fetched data if its index < IMG_H, else all-zero, with no fetch issued.
- States:
  - IDLE: start=1 -> PRIME; lines cleared to zero, so top padding is implicit.
  - PRIME: H steps for rows 0..H-1, then -> FILL.
  - FILL: step with row r+H, then -> EMIT.
  - EMIT: win_valid=1, window and win_row_idx stable until handshake.
  - WAIT: handshake done, staged row not yet returned.
- Fetch: one request outstanding max. fetch_req and fetch_addr are held stable until fetch_valid. Data is captured in the same cycle fetch_valid is seen, so zero-latency memory is legal.
- Prefetch: on the first EMIT cycle of row r, if r+1+H < IMG_H, request row r+1+H into the stage register.
- On handshake (win_valid & win_ready) for r < IMG_H-1, the step uses:
  - the stage register if full;
  - fetch_data if fetch_valid arrives in that same cycle;
  - zero if r+1+H >= IMG_H.
  - In all three cases win_row_idx <= r+1 and win_valid stays high (back-to-back).
  - Otherwise -> WAIT. On fetch_valid: step, -> EMIT next cycle.
- On handshake for r = IMG_H-1: frame_done=1 that cycle; next cycle busy=0, win_valid=0, state IDLE.
- Latency: with zero-latency memory, fetch_req rises the cycle after start is accepted; first win_valid is H+2 cycles after the start cycle.
- Throughput: 1 window/cycle with zero-latency memory and win_ready held high.
- K=1: PRIME is empty; window = current row only.
- IMG_H <= H: PRIME issues only in-range fetches; zero fills the rest.

Decomposition:
- Shared package: ROW_BITS/H derivation functions, state enum (IDLE, PRIME, FILL, EMIT, WAIT), and a parameter-legality assertion macro.
- Sub-module line_shift_reg: K x ROW_BITS shift register with synchronous clear and step/new_row inputs. The FSM and fetch control stay in the top level.

Test Plan:
- Zero-latency memory returning data = row index replicated; K=3, IMG_H=4, win_ready=1 -> windows r=0..3 are {0,row0,row1}, {row0,row1,row2}, {row1,row2,row3}, {row2,row3,0}; one window per cycle after the first; frame_done on r=3; exactly 4 fetches, addresses 0,1,2,3.
- Memory latency 5 cycles, win_ready=1 -> fetch_addr/fetch_req held stable 5 cycles each; WAIT entered; window contents identical to the zero-latency case.
- win_ready held low 10 cycles at r=1 -> win_rows and win_row_idx stable; at most one prefetch (addr 3) issued and staged; no further fetch until handshake.
- K=5, IMG_H=2 -> window r=0 is {0,0,row0,row1,0}, r=1 is {0,row0,row1,0,0}; only addresses 0,1 fetched.
- rst asserted while fetch_req=1 in WAIT, then fetch_valid pulsed -> all outputs 0 the next cycle, pulse ignored; a new start runs a clean frame from r=0.
- start pulsed while busy -> ignored, no restart; the frame completes normally.
